// File: rtl/hpdcache_refill_ctrl.sv
// Refill controller: acknowledges the MSHR entry, collects a line from memory flits,
// writes it into the cache and optionally answers the core. Optional: HPDCACHE_REFILL_ERROR_EN.
module hpdcache_refill_ctrl #(
  parameter int unsigned MSHR_SET_WIDTH = 2,
  parameter int unsigned MSHR_WAY_WIDTH = 2,
  parameter int unsigned NLINE_WIDTH    = 34,
  parameter int unsigned TID_WIDTH      = 6,
  parameter int unsigned SID_WIDTH      = 3,
  parameter int unsigned WORD_WIDTH     = 64,
  parameter int unsigned LINE_WORDS     = 8,
  parameter int unsigned FLIT_WIDTH     = 128
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   mem_rsp_valid_i,
  output logic                                   mem_rsp_ready_o,
  input  logic [MSHR_WAY_WIDTH+MSHR_SET_WIDTH-1:0] mem_rsp_id_i,
  input  logic [FLIT_WIDTH-1:0]                  mem_rsp_data_i,
  input  logic                                   mem_rsp_last_i,
  input  logic                                   mem_rsp_error_i,
  output logic                                   mshr_ack_req_o,
  input  logic                                   mshr_ack_gnt_i,
  output logic                                   mshr_ack_o,
  output logic                                   mshr_ack_cs_o,
  output logic [MSHR_SET_WIDTH-1:0]              mshr_ack_set_o,
  output logic [MSHR_WAY_WIDTH-1:0]              mshr_ack_way_o,
  input  logic [TID_WIDTH-1:0]                   mshr_ack_req_id_i,
  input  logic [SID_WIDTH-1:0]                   mshr_ack_src_id_i,
  input  logic [NLINE_WIDTH-1:0]                 mshr_ack_nline_i,
  input  logic [$clog2(LINE_WORDS)-1:0]          mshr_ack_word_i,
  input  logic                                   mshr_ack_need_rsp_i,
  input  logic                                   mshr_ack_is_prefetch_i,
  output logic                                   refill_valid_o,
  input  logic                                   refill_ready_i,
  output logic [NLINE_WIDTH-1:0]                 refill_nline_o,
  output logic [LINE_WORDS*WORD_WIDTH-1:0]       refill_data_o,
  output logic                                   core_rsp_valid_o,
  input  logic                                   core_rsp_ready_i,
  output logic [TID_WIDTH-1:0]                   core_rsp_tid_o,
  output logic [SID_WIDTH-1:0]                   core_rsp_sid_o,
  output logic [WORD_WIDTH-1:0]                  core_rsp_rdata_o,
  output logic                                   core_rsp_error_o,
  output logic                                   busy_o
);

  localparam int unsigned LINE_WIDTH = LINE_WORDS * WORD_WIDTH;
  localparam int unsigned FLITS      = LINE_WIDTH / FLIT_WIDTH;
  localparam int unsigned FCNT_W     = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int unsigned WIDX_W     = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_META,
    ST_DATA,
    ST_REFILL,
    ST_RSP
  } state_e;

  state_e                                 state_q;
  logic [MSHR_SET_WIDTH-1:0]              set_q;
  logic [MSHR_WAY_WIDTH-1:0]              way_q;
  logic [FCNT_W-1:0]                      flit_cnt_q;
  logic [TID_WIDTH-1:0]                   tid_q;
  logic [SID_WIDTH-1:0]                   sid_q;
  logic [NLINE_WIDTH-1:0]                 nline_q;
  logic [WIDX_W-1:0]                      word_q;
  logic                                   need_rsp_q;
  logic                                   prefetch_q;
  logic [FLITS-1:0][FLIT_WIDTH-1:0]       buf_q;
  logic [LINE_WORDS-1:0][WORD_WIDTH-1:0]  line_words;
  logic                                   want_rsp;
  logic                                   last_flit;
  logic                                   line_err;

`ifdef HPDCACHE_REFILL_ERROR_EN
  logic err_q;
  logic unused_inputs;
  assign unused_inputs = mem_rsp_last_i;
  assign line_err      = err_q | mem_rsp_error_i;
  assign core_rsp_error_o = err_q;
`else
  logic unused_inputs;
  assign unused_inputs    = ^{mem_rsp_last_i, mem_rsp_error_i};
  assign line_err         = 1'b0;
  assign core_rsp_error_o = 1'b0;
`endif

  assign want_rsp  = need_rsp_q & ~prefetch_q;
  assign last_flit = (flit_cnt_q == FCNT_W'(FLITS - 1));

  assign busy_o           = (state_q != ST_IDLE);
  assign mshr_ack_req_o   = (state_q == ST_ACK);
  assign mshr_ack_o       = mshr_ack_req_o & mshr_ack_gnt_i;
  assign mshr_ack_cs_o    = mshr_ack_o;
  assign mshr_ack_set_o   = set_q;
  assign mshr_ack_way_o   = way_q;
  assign mem_rsp_ready_o  = (state_q == ST_DATA);
  assign refill_valid_o   = (state_q == ST_REFILL);
  assign refill_nline_o   = nline_q;
  assign refill_data_o    = buf_q;
  assign core_rsp_valid_o = (state_q == ST_RSP);
  assign core_rsp_tid_o   = tid_q;
  assign core_rsp_sid_o   = sid_q;
  assign line_words       = buf_q;
  assign core_rsp_rdata_o = line_words[word_q];

  // Line completion is decided by the flit counter alone; the memory "last" flag is advisory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      set_q      <= '0;
      way_q      <= '0;
      flit_cnt_q <= '0;
      tid_q      <= '0;
      sid_q      <= '0;
      nline_q    <= '0;
      word_q     <= '0;
      need_rsp_q <= 1'b0;
      prefetch_q <= 1'b0;
`ifdef HPDCACHE_REFILL_ERROR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mem_rsp_valid_i) begin
            set_q   <= mem_rsp_id_i[MSHR_SET_WIDTH-1:0];
            way_q   <= mem_rsp_id_i[MSHR_SET_WIDTH +: MSHR_WAY_WIDTH];
            state_q <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (mshr_ack_gnt_i) state_q <= ST_META;
        end
        ST_META: begin
          tid_q      <= mshr_ack_req_id_i;
          sid_q      <= mshr_ack_src_id_i;
          nline_q    <= mshr_ack_nline_i;
          word_q     <= mshr_ack_word_i;
          need_rsp_q <= mshr_ack_need_rsp_i;
          prefetch_q <= mshr_ack_is_prefetch_i;
          flit_cnt_q <= '0;
`ifdef HPDCACHE_REFILL_ERROR_EN
          err_q      <= 1'b0;
`endif
          state_q    <= ST_DATA;
        end
        ST_DATA: begin
          if (mem_rsp_valid_i) begin
            flit_cnt_q <= flit_cnt_q + FCNT_W'(1);
`ifdef HPDCACHE_REFILL_ERROR_EN
            err_q      <= line_err;
`endif
            if (last_flit) begin
              flit_cnt_q <= '0;
              if (line_err) state_q <= want_rsp ? ST_RSP : ST_IDLE;
              else          state_q <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          if (refill_ready_i) state_q <= want_rsp ? ST_RSP : ST_IDLE;
        end
        ST_RSP: begin
          if (core_rsp_ready_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The line buffer carries no reset; its contents only matter once a line has been collected.
  always_ff @(posedge clk_i) begin
    if (mem_rsp_ready_o && mem_rsp_valid_i) buf_q[flit_cnt_q] <= mem_rsp_data_i;
  end

endmodule

// File: tb/tb_hpdcache_refill_ctrl.sv
// Randomized self-checking bench for hpdcache_refill_ctrl against a transaction-level line model.
// Honours HPDCACHE_REFILL_ERROR_EN when it is defined for the build.
module tb_hpdcache_refill_ctrl;

  localparam int FLITS = 4;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         mem_rsp_valid_i = 1'b0;
  logic         mem_rsp_ready_o;
  logic [3:0]   mem_rsp_id_i = '0;
  logic [127:0] mem_rsp_data_i = '0;
  logic         mem_rsp_last_i = 1'b0;
  logic         mem_rsp_error_i = 1'b0;
  logic         mshr_ack_req_o;
  logic         mshr_ack_gnt_i = 1'b0;
  logic         mshr_ack_o;
  logic         mshr_ack_cs_o;
  logic [1:0]   mshr_ack_set_o;
  logic [1:0]   mshr_ack_way_o;
  logic [5:0]   mshr_ack_req_id_i = '0;
  logic [2:0]   mshr_ack_src_id_i = '0;
  logic [33:0]  mshr_ack_nline_i = '0;
  logic [2:0]   mshr_ack_word_i = '0;
  logic         mshr_ack_need_rsp_i = 1'b0;
  logic         mshr_ack_is_prefetch_i = 1'b0;
  logic         refill_valid_o;
  logic         refill_ready_i = 1'b0;
  logic [33:0]  refill_nline_o;
  logic [511:0] refill_data_o;
  logic         core_rsp_valid_o;
  logic         core_rsp_ready_i = 1'b0;
  logic [5:0]   core_rsp_tid_o;
  logic [2:0]   core_rsp_sid_o;
  logic [63:0]  core_rsp_rdata_o;
  logic         core_rsp_error_o;
  logic         busy_o;

  hpdcache_refill_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_id_i(mem_rsp_id_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_last_i(mem_rsp_last_i), .mem_rsp_error_i(mem_rsp_error_i),
    .mshr_ack_req_o(mshr_ack_req_o), .mshr_ack_gnt_i(mshr_ack_gnt_i),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
    .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
    .mshr_ack_req_id_i(mshr_ack_req_id_i), .mshr_ack_src_id_i(mshr_ack_src_id_i),
    .mshr_ack_nline_i(mshr_ack_nline_i), .mshr_ack_word_i(mshr_ack_word_i),
    .mshr_ack_need_rsp_i(mshr_ack_need_rsp_i), .mshr_ack_is_prefetch_i(mshr_ack_is_prefetch_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_nline_o(refill_nline_o), .refill_data_o(refill_data_o),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_tid_o(core_rsp_tid_o), .core_rsp_sid_o(core_rsp_sid_o),
    .core_rsp_rdata_o(core_rsp_rdata_o), .core_rsp_error_o(core_rsp_error_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Expected view of the line currently in flight
  logic [1:0]   expSet, expWay;
  logic [33:0]  expNline;
  logic [511:0] expLine;
  logic [5:0]   expTid;
  logic [2:0]   expSid;
  logic [63:0]  expRdata;
  logic         expErr = 1'b0;

  int ackCount = 0, refillCount = 0, rspCount = 0;
  logic [1:0]  lastAckSet, lastAckWay;
  logic [63:0] lastRspData;

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare of every output that is meaningful in that cycle
  always @(negedge clk) begin
    if (rst_ni) begin
      checkOutput("ackWithoutGnt", 512'(mshr_ack_o & ~mshr_ack_gnt_i), 0);
      checkOutput("readyOutsideData",
                  512'(mem_rsp_ready_o & (refill_valid_o | core_rsp_valid_o | mshr_ack_req_o)), 0);
      if (mshr_ack_o) begin
        ackCount++;
        lastAckSet = mshr_ack_set_o;
        lastAckWay = mshr_ack_way_o;
        checkOutput("ackCs", 512'(mshr_ack_cs_o), 1);
        checkOutput("ackSet", 512'(mshr_ack_set_o), 512'(expSet));
        checkOutput("ackWay", 512'(mshr_ack_way_o), 512'(expWay));
      end
      if (refill_valid_o) begin
        checkOutput("refillNline", 512'(refill_nline_o), 512'(expNline));
        checkOutput("refillData", refill_data_o, expLine);
        if (refill_ready_i) refillCount++;
      end
      if (core_rsp_valid_o) begin
        checkOutput("rspTid", 512'(core_rsp_tid_o), 512'(expTid));
        checkOutput("rspSid", 512'(core_rsp_sid_o), 512'(expSid));
        checkOutput("rspError", 512'(core_rsp_error_o), 512'(expErr));
        if (!expErr) checkOutput("rspRdata", 512'(core_rsp_rdata_o), 512'(expRdata));
        if (core_rsp_ready_i) begin
          rspCount++;
          lastRspData = core_rsp_rdata_o;
        end
      end
`ifndef HPDCACHE_REFILL_ERROR_EN
      checkOutput("errorTiedLow", 512'(core_rsp_error_o), 0);
`endif
    end
  end

  task automatic driveJunkReadback();
    mshr_ack_req_id_i      = 6'($urandom);
    mshr_ack_src_id_i      = 3'($urandom);
    mshr_ack_nline_i       = 34'({$urandom, $urandom});
    mshr_ack_word_i        = 3'($urandom);
    mshr_ack_need_rsp_i    = 1'($urandom);
    mshr_ack_is_prefetch_i = 1'($urandom);
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "_busy"}, 512'(busy_o), 0);
    checkOutput({tag, "_ready"}, 512'(mem_rsp_ready_o), 0);
    checkOutput({tag, "_ackReq"}, 512'(mshr_ack_req_o), 0);
    checkOutput({tag, "_ack"}, 512'(mshr_ack_o), 0);
    checkOutput({tag, "_refill"}, 512'(refill_valid_o), 0);
    checkOutput({tag, "_rsp"}, 512'(core_rsp_valid_o), 0);
    checkOutput({tag, "_err"}, 512'(core_rsp_error_o), 0);
    checkOutput({tag, "_tid"}, 512'(core_rsp_tid_o), 0);
    checkOutput({tag, "_nline"}, 512'(refill_nline_o), 0);
  endtask

  // One complete line transaction; called and returns at #1 after a rising edge
  task automatic applyStimulus(input logic [3:0] id, input int gd, input int rd, input int cd,
                               input bit bubbles, input int abortAfter, input int errIdx,
                               input logic needRsp, input logic pf, input logic [2:0] wd,
                               input bit pattern, input bit checkLat);
    logic [127:0] flits [FLITS];
    bit acked, done, acc, errEff, expRefill, expRsp, seenRefill;
    int n, i, reqCnt, waitc, startCyc, refCyc;
    for (int f = 0; f < FLITS; f++)
      for (int h = 0; h < 2; h++)
        flits[f][h*64 +: 64] = pattern ? (64'hC0DE_0000_0000_0000 | 64'(f*2 + h))
                                       : {$urandom, $urandom};
    for (int f = 0; f < FLITS; f++) expLine[f*128 +: 128] = flits[f];
    expSet   = id[1:0];
    expWay   = id[3:2];
    expTid   = 6'($urandom);
    expSid   = 3'($urandom);
    expNline = 34'({$urandom, $urandom});
    expRdata = expLine[wd*64 +: 64];
`ifdef HPDCACHE_REFILL_ERROR_EN
    errEff = (errIdx >= 0);
`else
    errEff = 1'b0;
`endif
    expErr    = errEff;
    expRefill = !errEff;
    expRsp    = needRsp && !pf;
    ackCount = 0; refillCount = 0; rspCount = 0;

    driveJunkReadback();
    mem_rsp_id_i    = id;
    mem_rsp_data_i  = flits[0];
    mem_rsp_last_i  = (FLITS == 1);
    mem_rsp_error_i = (errIdx == 0);
    mem_rsp_valid_i = 1'b1;
    mshr_ack_gnt_i  = (gd == 0);
    startCyc = cyc;

    acked = 0; n = 0; reqCnt = 0;
    while (!acked && n < 200) begin
      @(negedge clk);
      if (mshr_ack_o) acked = 1;
      else if (mshr_ack_req_o) reqCnt++;
      @(posedge clk); #1;
      if (!acked) mshr_ack_gnt_i = (reqCnt >= gd);
      n++;
    end
    mshr_ack_gnt_i = 1'b0;
    checkOutput("ackSeen", 512'(acked), 1);
    checkOutput("grantWait", 512'(reqCnt), 512'(gd));
    if (!acked) return;

    mshr_ack_req_id_i      = expTid;
    mshr_ack_src_id_i      = expSid;
    mshr_ack_nline_i       = expNline;
    mshr_ack_word_i        = wd;
    mshr_ack_need_rsp_i    = needRsp;
    mshr_ack_is_prefetch_i = pf;
    @(posedge clk); #1;
    driveJunkReadback();

    i = 0; n = 0;
    while (i < FLITS && n < 400) begin
      mem_rsp_valid_i = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_rsp_data_i  = flits[i];
      mem_rsp_last_i  = (i == FLITS - 1);
      mem_rsp_error_i = (i == errIdx);
      @(negedge clk);
      acc = mem_rsp_valid_i && mem_rsp_ready_o;
      @(posedge clk); #1;
      if (acc) i++;
      n++;
      if (acc && i == abortAfter) begin
        rst_ni = 1'b0;
        mem_rsp_valid_i = 1'b0;
        #2;
        checkAllLow("abortReset");
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        checkOutput("abortIdle", 512'(busy_o), 0);
        return;
      end
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    mem_rsp_error_i = 1'b0;
    checkOutput("allFlitsTaken", 512'(i), FLITS);

    if (expRefill) begin
      done = 0; n = 0; waitc = 0; seenRefill = 0; refCyc = 0;
      while (!done && n < 200) begin
        refill_ready_i = (waitc >= rd);
        @(negedge clk);
        if (refill_valid_o) begin
          if (!seenRefill) refCyc = cyc;
          seenRefill = 1;
          if (refill_ready_i) done = 1;
          waitc++;
        end
        @(posedge clk); #1;
        n++;
      end
      refill_ready_i = 1'b0;
      checkOutput("refillDone", 512'(done), 1);
      if (checkLat) checkOutput("refillLatency", 512'(refCyc - startCyc), 512'(3 + FLITS));
    end

    if (expRsp) begin
      done = 0; n = 0; waitc = 0;
      while (!done && n < 200) begin
        core_rsp_ready_i = (waitc >= cd);
        @(negedge clk);
        if (core_rsp_valid_o) begin
          if (core_rsp_ready_i) done = 1;
          waitc++;
        end
        @(posedge clk); #1;
        n++;
      end
      core_rsp_ready_i = 1'b0;
      checkOutput("rspDone", 512'(done), 1);
    end

    checkOutput("ackOnce", 512'(ackCount), 1);
    checkOutput("refillCount", 512'(refillCount), 512'(expRefill));
    checkOutput("rspCount", 512'(rspCount), 512'(expRsp));
    checkOutput("idleAfterLine", 512'(busy_o), 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    #1;
    checkAllLow("reset");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Immediate grant, word 5 of a patterned line
    applyStimulus(4'h6, 0, 0, 0, 0, -1, -1, 1'b1, 1'b0, 3'd5, 1, 1);
    checkOutput("litAckSet", 512'(lastAckSet), 2);
    checkOutput("litAckWay", 512'(lastAckWay), 1);
    checkOutput("litRdata", 512'(lastRspData), 512'(64'hC0DE_0000_0000_0005));

    // Grant withheld for 10 cycles
    applyStimulus(4'h9, 10, 0, 0, 0, -1, -1, 1'b1, 1'b0, 3'd2, 0, 0);
    // Prefetch never answers the core
    applyStimulus(4'h3, 0, 1, 0, 1, -1, -1, 1'b1, 1'b1, 3'd7, 0, 0);
    // Backpressure on refill then on core response
    applyStimulus(4'hC, 1, 5, 3, 0, -1, -1, 1'b1, 1'b0, 3'd0, 0, 0);
    // Memory error on flit 2
    applyStimulus(4'h5, 0, 0, 1, 0, -1, 2, 1'b1, 1'b0, 3'd4, 0, 0);
    // Reset mid-line after two flits, then a clean line
    applyStimulus(4'hA, 0, 0, 0, 0, 2, -1, 1'b1, 1'b0, 3'd1, 0, 0);
    applyStimulus(4'h6, 0, 0, 0, 0, -1, -1, 1'b1, 1'b0, 3'd5, 1, 1);

    for (int t = 0; t < 40; t++) begin
      applyStimulus(4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    1, -1, ($urandom_range(0, 7) == 0) ? $urandom_range(0, FLITS - 1) : -1,
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                    3'($urandom), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
